// File: rtl/pipeline_ctrl.sv
// Hazard/flush scheduler for the 5-stage pipeline.
// Drives stage-register holds and squashes; counts load-use bubbles.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             br_mispredict,
  input  logic [11:0]      br_target,
  input  logic             halt_confirm,
  input  logic             mem_busy,
  output logic             pc_latchn,
  output logic             ifid_latchn,
  output logic             idex_latchn,
  output logic             exmem_latchn,
  output logic             memwb_latchn,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pc_redirect,
  output logic [11:0]      pc_redirect_target,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state_q, state_d;
  logic [1:0]       dcnt_q, dcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic misp, hlt, ld_use, rs_hit;

  assign misp   = ex_valid & br_mispredict;
  assign hlt    = ex_valid & halt_confirm;
  assign rs_hit = (id_use_rs1 & (id_rs1 == ex_rd))
                | (id_use_rs2 & (id_rs2 == ex_rd));
  assign ld_use = ex_valid & ex_is_load & (ex_rd != 5'd0)
                & id_valid & rs_hit;

  assign pc_redirect_target = br_target;
  assign stall_cnt          = stall_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= RUN;
      dcnt_q      <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    stall_cnt_d  = stall_cnt_q;
    pc_latchn    = 1'b0;
    ifid_latchn  = 1'b0;
    idex_latchn  = 1'b0;
    exmem_latchn = 1'b0;
    memwb_latchn = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    pc_redirect  = 1'b0;
    halted       = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          pc_latchn    = 1'b1;
          ifid_latchn  = 1'b1;
          idex_latchn  = 1'b1;
          exmem_latchn = 1'b1;
          memwb_latchn = 1'b1;
        end else if (misp) begin
          pc_redirect = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
        end else if (hlt) begin
          pc_latchn  = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = DRAIN;
          dcnt_d     = 2'd2;
        end else if (ld_use) begin
          pc_latchn   = 1'b1;
          ifid_latchn = 1'b1;
          idex_flush  = 1'b1;
          if (stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
      end
      DRAIN: begin
        pc_latchn   = 1'b1;
        ifid_latchn = 1'b1;
        if (mem_busy) begin
          idex_latchn  = 1'b1;
          exmem_latchn = 1'b1;
          memwb_latchn = 1'b1;
        end else begin
          idex_flush = 1'b1;
          dcnt_d     = dcnt_q - 2'd1;
          if (dcnt_q == 2'd1)
            state_d = HALTED;
        end
      end
      HALTED: begin
        pc_latchn    = 1'b1;
        ifid_latchn  = 1'b1;
        idex_latchn  = 1'b1;
        exmem_latchn = 1'b1;
        memwb_latchn = 1'b1;
        halted       = 1'b1;
      end
      default: state_d = RUN;
    endcase

    // Reset overrides every control so nothing advances while held.
    if (!RSTn) begin
      pc_latchn    = 1'b1;
      ifid_latchn  = 1'b1;
      idex_latchn  = 1'b1;
      exmem_latchn = 1'b1;
      memwb_latchn = 1'b1;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      pc_redirect  = 1'b0;
      halted       = 1'b0;
    end
  end

endmodule
